// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed 32x32 multiply / 32/32 divide responder.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   start     in   one-cycle request pulse, sampled only in IDLE or DONE
//   op        in   0 = MULT (signed), 1 = DIV (signed); captured with start
//   a, b      in   32-bit operands; captured with start
//   busy      out  operation in progress (CALC, FIX)
//   done      out  one-cycle pulse; hi/lo are valid from this cycle on
//   div_zero  out  one-cycle pulse with done for DIV with b == 0
//   hi, lo    out  MULT: product[63:32] / product[31:0]; DIV: remainder / quotient
//
// Handshake: start is a request pulse accepted at a rising edge only while
// busy is low; a start seen while busy is dropped, not queued. Each accepted
// request produces exactly one done pulse unless reset aborts it first.
//
// The datapath works on magnitudes (33 bits so |0x80000000| fits) and
// applies the sign correction in a single FIX cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic        op_r;
  logic        sign_a;
  logic        sign_b;
  logic [5:0]  cnt;
  logic [32:0] mag_b;    // MULT: multiplier, shifted right; DIV: divisor, constant
  logic [63:0] mcand;    // MULT: multiplicand, shifted left each step
  logic [63:0] acc;      // MULT: product accumulator
  logic [32:0] rem;      // DIV: partial remainder
  logic [31:0] quo;      // DIV: dividend in, quotient out (shift register)

  logic [32:0] a_ext, b_ext, abs_a, abs_b;
  logic [32:0] rem_shift, rem_sub;
  logic        rem_ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Operand magnitudes, computed on the 33-bit sign extension.
  always_comb begin
    a_ext = {a[31], a};
    b_ext = {b[31], b};
    abs_a = a[31] ? (~a_ext + 33'd1) : a_ext;
    abs_b = b[31] ? (~b_ext + 33'd1) : b_ext;
  end

  // Restoring division step: shift in the next dividend bit, then subtract
  // the divisor if it fits.
  always_comb begin
    rem_shift = (rem << 1) | {32'd0, quo[31]};
    rem_ge    = (rem_shift >= mag_b);
    rem_sub   = rem_shift - mag_b;
  end

  // Sign correction: product/quotient negative when operand signs differ,
  // remainder follows the dividend.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
    quo_fix  = (sign_a ^ sign_b) ? (~quo + 32'd1) : quo;
    rem_fix  = sign_a ? (~rem[31:0] + 32'd1) : rem[31:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      op_r     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      cnt      <= 6'd0;
      mag_b    <= 33'd0;
      mcand    <= 64'd0;
      acc      <= 64'd0;
      rem      <= 33'd0;
      quo      <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            op_r   <= op;
            sign_a <= a[31];
            sign_b <= b[31];
            cnt    <= 6'd0;
            mag_b  <= abs_b;
            mcand  <= {31'd0, abs_a};
            acc    <= 64'd0;
            rem    <= 33'd0;
            quo    <= abs_a[31:0];
            if (op && (b == 32'd0)) begin
              // Divide by zero: flag at once, hi/lo keep their old value.
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end

        CALC: begin
          if (op_r) begin
            rem <= rem_ge ? rem_sub : rem_shift;
            quo <= {quo[30:0], rem_ge};
          end else begin
            if (mag_b[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mag_b <= mag_b >> 1;
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end

        FIX: begin
          if (op_r) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against
// a plain-arithmetic reference model (64-bit signed multiply, truncating
// signed divide and remainder).
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] exp_q[$];
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  // clock / reset block
  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  // Reference model: HI/LO register contents after an operation.
  function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                output logic dz);
    longint p, q, r;
    dz = 1'b0;
    if (!o) begin
      p = longint'($signed(x)) * longint'($signed(y));
      mdl_hi = p[63:32];
      mdl_lo = p[31:0];
    end else if (y == 32'd0) begin
      dz = 1'b1;
    end else begin
      q = longint'($signed(x)) / longint'($signed(y));
      r = longint'($signed(x)) % longint'($signed(y));
      mdl_hi = r[31:0];
      mdl_lo = q[31:0];
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver: called at a negedge; issues one request and follows it to done.
  // Returns positioned at the done-cycle negedge so a caller can chain.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    logic        dz;
    int          k;
    int          busy_cnt;
    logic [63:0] e;
    model(o, x, y, dz);
    exp_q.push_back({mdl_hi, mdl_lo});
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && k < 60) begin
      if (busy === 1'b1) busy_cnt++;
      if (k == 2) begin
        // Operand changes after capture must not matter.
        a = $urandom; b = $urandom; op = ~o;
      end
      @(negedge clk);
      k++;
    end
    e = exp_q.pop_front();
    chk({tag, ".latency"}, 64'(k), dz ? 64'd1 : 64'd34);
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), dz ? 64'd0 : 64'd33);
    chk({tag, ".busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({tag, ".div_zero"}, {63'd0, div_zero}, {63'd0, dz});
    chk({tag, ".hi_lo"}, {hi, lo}, e);
  endtask

  int          k;
  int          ndone;
  int          first_k;
  logic [63:0] got;
  logic [63:0] e;
  logic        dz;
  logic        ro;
  logic [31:0] rx, ry;

  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    idle(3);
    chk("reset.flags", {61'd0, busy, done, div_zero}, 64'd0);
    chk("reset.hi_lo", {hi, lo}, 64'd0);
    reset = 1'b1;
    idle(1);

    // Reset and start at the same edge: reset wins, start is lost.
    reset = 1'b0; start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd3;
    @(negedge clk);
    chk("rst_start.busy", {63'd0, busy}, 64'd0);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst_start.not_queued", {62'd0, busy, done}, 64'd0);

    run_op(1'b0, 32'd7, 32'hFFFFFFFD, "mult_neg");
    idle(2);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, "div_neg");
    run_op(1'b1, 32'd100, 32'd7, "div_b2b");
    idle(1);
    run_op(1'b1, 32'd5, 32'd0, "div_zero");
    chk("div_zero.retained", {hi, lo}, {32'd2, 32'd14});
    idle(1);
    run_op(1'b0, 32'h80000000, 32'h80000000, "mult_min_min");
    idle(1);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_min_m1");
    idle(1);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "mult_m1_m1");
    idle(2);

    // Start while busy is ignored: exactly one done, for 3 x 5.
    model(1'b0, 32'd3, 32'd5, dz);
    exp_q.push_back({mdl_hi, mdl_lo});
    op = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; first_k = 0; got = 64'd0;
    k = 1;
    repeat (80) begin
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first_k = k;
          got = {hi, lo};
        end
      end
      start = (k == 5);
      if (k == 5) begin a = 32'h1234; b = 32'h77; end
      @(negedge clk);
      k++;
    end
    e = exp_q.pop_front();
    chk("busy_start.done_count", 64'(ndone), 64'd1);
    chk("busy_start.latency", 64'(first_k), 64'd34);
    chk("busy_start.hi_lo", got, e);

    // Reset mid-operation aborts with no done.
    op = 1'b0; a = 32'h1111; b = 32'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i < 10; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
    chk("abort.busy", {63'd0, busy}, 64'd0);
    chk("abort.hi_lo", {hi, lo}, 64'd0);
    reset = 1'b1;
    repeat (50) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort.no_done", 64'(ndone), 64'd0);

    run_op(1'b0, 32'd2, 32'd3, "mult_after_reset");

    // Randomized operations with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: rx = 32'h80000000;
        2: ry = 32'hFFFFFFFF;
        3: begin rx = 32'($urandom_range(0, 20)); ry = 32'($urandom_range(1, 5)); end
        4: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
        default: ;
      endcase
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
      run_op(ro, rx, ry, "random");
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide responder for the MIPS datapath. The control FSM starts an operation with a one-cycle `start` pulse and waits for `done`. The unit returns the 64-bit product, or the quotient and remainder, on registered `hi`/`lo` outputs, which the datapath routes into the HI/LO register path. `div_zero` drives the divide-by-zero exception input of the control FSM.

## Interface
- No parameters; the width is fixed at 32 bits.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low. `reset`=0 sampled at a rising edge resets the unit.
- `start` in 1: request. Sampled only when the unit is not busy.
- `op` in 1: 0 = MULT (signed), 1 = DIV (signed). Captured with `start`.
- `a` in 32: multiplicand or dividend (from register A). Captured with `start`.
- `b` in 32: multiplier or divisor (from register B). Captured with `start`.
- `busy` out 1: operation in progress; `start` is ignored while high.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid from this cycle on.
- `div_zero` out 1: one-cycle pulse, coincident with `done`, for DIV with `b`=0.
- `hi` out 32: MULT gives product[63:32]; DIV gives the remainder.
- `lo` out 32: MULT gives product[31:0]; DIV gives the quotient.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE/DONE, `start`=1 at an edge:**
  - Capture `op`, the sign of `a`, the sign of `b`, |a| and |b| (33-bit magnitudes, so |0x80000000| is representable).
  - Clear the 6-bit iteration counter.
  - Go to CALC.
  - Exception: DIV with `b`=0 goes to DONE with `div_zero`=1 and leaves `hi`/`lo` unchanged.
- **IDLE/DONE, `start`=0:** go to IDLE.
- **CALC:** one radix-2 step per clock, 32 steps.
  - MULT: shift-add on a 64-bit accumulator.
  - DIV: restoring division on a 33-bit partial remainder and the quotient shift register.
  - After the step with counter=31, go to FIX.
- **FIX:** apply the sign correction and load `hi`/`lo`, then go to DONE.
  - MULT: negate the 64-bit product if sign(a)≠sign(b).
  - DIV: negate the quotient if sign(a)≠sign(b); the remainder takes the sign of the dividend.
  - The quotient truncates toward zero.
- **DONE:** `done`=1 for this one cycle only. A new `start` is accepted here (back-to-back operation).
- **Width rules:**
  - All arithmetic is two's complement; results wrap modulo 2^32 per half.
  - 0x80000000 / 0xFFFFFFFF yields `lo`=0x80000000, `hi`=0, with no flag and no exception.
- **Output hold:** `hi`/`lo` hold their value until the next FIX or reset. Changes on `a`, `b` or `op` after the capture edge have no effect.
- **Flags:** `busy`=1 in CALC and FIX; 0 in IDLE and DONE. `div_zero` is high only in a DONE entered from a divide-by-zero.

## Timing
- **Reset values:** IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, counter=0.
- **Reset mid-operation:** `reset`=0 in any state aborts the operation and applies the reset values at that edge. No `done` is issued for the aborted operation.
- **Normal latency:** edge E0 samples `start`.
  - `busy`=1 from E0 to E33.
  - FIX occurs at E33; `hi`/`lo` update at E33.
  - `done`=1 in the cycle between E33 and E34.
  - Total: 34 clocks from request to `done`.
- **Divide-by-zero latency:** `done`=`div_zero`=1 in the cycle right after E0 (1 clock). `busy` never rises.
- **Start while busy:** `start`=1 in CALC or FIX is ignored. It is not queued.
- **Reset and start together:** `reset`=0 and `start`=1 at the same edge resolves to reset; the start is lost.
- **Back-to-back:** `start` sampled in DONE begins a new operation. `done` drops on the following cycle and `busy` rises.

## Test plan
- After reset, MULT `a`=7, `b`=0xFFFFFFFD → `busy` high for 33 cycles; `done` pulses 34 clocks after the start edge; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV `a`=0xFFFFFFF9 (−7), `b`=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1), `div_zero`=0. Then DIV 100/7 started in the DONE cycle → `lo`=14, `hi`=2, 34 clocks later.
- After the result 14/2, DIV `a`=5, `b`=0 → `done`=`div_zero`=1 one clock after start, `busy` never high, `hi`=2 and `lo`=14 retained.
- Corners:
  - MULT 0x80000000×0x80000000 → `hi`=0x40000000, `lo`=0.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - MULT 0xFFFFFFFF×0xFFFFFFFF → `hi`=0, `lo`=1.
- Robustness:
  - Start MULT 3×5; change `a`/`b` and pulse `start` at cycle 5 → single `done` with `lo`=15, `hi`=0.
  - Start another MULT and drive `reset`=0 at cycle 10 → next cycle `busy`=0 and `hi`=`lo`=0, with no `done` ever issued.
  - A fresh MULT 2×3 after reset → `lo`=6.
